addsub_byte_sequencer: RTL

Multi-byte add/subtract sequencer that sits directly upstream of the 8-bit adder/subtractor stage.
- Latches two N-byte operands and an add/sub select.
- Drives the 8-bit adder one byte per cycle, LSB first, and feeds each byte's carry-out back as the next byte's carry-in.
- Assembles the wide result plus carry/overflow/zero flags for the ALU result path.
- The adder is external and purely combinational; this block owns its operand, mode and carry-in pins.

---
 rtl/addsub_byte_sequencer_pkg.sv | 15 +
 rtl/addsub_byte_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/addsub_byte_sequencer_pkg.sv
// Shared ALU definitions: sequencer state encoding and add/sub opcode
// constants. The ALU decoder imports the same constants so the opcode
// meaning stays in one place.
package addsub_byte_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_byte_sequencer.sv
// Multi-byte add/subtract sequencer in front of an external combinational
// 8-bit adder/subtractor. Operands are latched on start, then fed to the
// adder one byte per cycle, LSB first, with each carry-out rippled into the
// next byte's carry-in. The wide result and its flags are assembled here.
//
// Handshake: start is a request that is accepted only in IDLE; there is no
// backpressure and requests arriving while busy are dropped, not queued.
// done is a one-cycle pulse marking result/carry_out/overflow/zero valid;
// those values then hold until the next accepted start clears them.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, op_sub     request and mode (0 = A+B, 1 = A-B)
//   a_in, b_in        W-bit operands, sampled with start
//   busy, done        status (busy in RUN and DONE), result-valid pulse
//   result            assembled W-bit sum/difference
//   carry_out         bit W of the operation (sub: 1 = no borrow)
//   overflow, zero    signed overflow, result == 0
//   add_m/a/b/cin     drive to the adder (mode, byte operands, carry-in)
//   add_sum, add_cout response from the adder
module addsub_byte_sequencer
    import addsub_byte_sequencer_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  zero,
    output logic                  add_m,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    state_t                      state_q;
    logic [IDXW-1:0]             idx_q;
    logic [NBYTES-1:0][7:0]      a_q;
    logic [NBYTES-1:0][7:0]      b_q;
    logic [NBYTES-1:0][7:0]      res_q;
    logic                        op_q;
    logic                        carry_q;
    logic                        cout_q;
    logic                        ovf_q;
    logic                        done_q;
    logic                        busy_q;

    // Sign of the effective second operand: B inverted for subtraction.
    logic                        y_msb;
    assign y_msb = b_q[NBYTES-1][7] ^ op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        op_q    <= op_sub;
                        // Subtraction is A + ~B + 1: seed the chain with 1.
                        carry_q <= (op_sub == OP_SUB);
                        idx_q   <= '0;
                        res_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_q[idx_q] <= add_sum;
                    carry_q      <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= add_cout;
                        // Overflow: operand signs agree but the result sign differs.
                        ovf_q   <= (a_q[NBYTES-1][7] == y_msb) &&
                                   (add_sum[7] != a_q[NBYTES-1][7]);
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Adder pins are only driven while a byte is being processed.
    assign add_a   = (state_q == ST_RUN) ? a_q[idx_q] : 8'h00;
    assign add_b   = (state_q == ST_RUN) ? b_q[idx_q] : 8'h00;
    assign add_m   = (state_q == ST_RUN) ? op_q       : 1'b0;
    assign add_cin = (state_q == ST_RUN) ? carry_q    : 1'b0;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = ~|res_q;

endmodule
